// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter that shares the register file's single write
//            port between two writeback requesters. Requester A is the ALU
//            writeback and requester B is the load/multicycle writeback.
//            Register 0 is hardwired to zero. A granted write to address 0 is
//            accepted, but it is not passed on to the register file.
// Option   : RF_CLEAR_EN - when defined, reset starts a clear sequence.
//            The sequence writes zero to registers 1..NUM_REGS-1, one per
//            cycle, and busy stays high while it runs. When the macro is not
//            defined, reset enters arbitration directly and busy is tied low.
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            a_req/a_addr/a_data   - requester A write request
//            a_gnt                 - A accepted this cycle (combinational)
//            b_req/b_addr/b_data   - requester B write request
//            b_gnt                 - B accepted this cycle (combinational)
//            busy                  - clear sequence in progress
//            rf_we/rf_waddr/rf_wdata - registered register file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  // Encoding of the side that won the most recent grant.
  localparam logic c_GNT_A = 1'b0;
  localparam logic c_GNT_B = 1'b1;

  logic              r_last_gnt;
  logic              w_last_gnt_d;
  logic              w_arb_en;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_we_d;
  logic [ADDR_W-1:0] w_waddr_d;
  logic [DATA_W-1:0] w_wdata_d;

`ifdef RF_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_d;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= ADDR_W'(1);
    end else begin
      r_state   <= w_state_d;
      r_clr_ptr <= w_clr_ptr_d;
    end
  end

  // The clear pointer advances each cycle. When the final address is written,
  // the FSM leaves CLEAR on that same edge. Because busy is decoded from the
  // state register, busy also falls on that edge.
  always_comb begin
    w_state_d   = r_state;
    w_clr_ptr_d = r_clr_ptr;
    if (r_state == ST_CLEAR) begin
      w_clr_ptr_d = r_clr_ptr + ADDR_W'(1);
      if (r_clr_ptr == c_LAST_ADDR) begin
        w_state_d = ST_ARB;
      end
    end
  end

  assign w_arb_en = (r_state == ST_ARB);
  assign busy     = (r_state == ST_CLEAR);
`else
  assign w_arb_en = 1'b1;
  assign busy     = 1'b0;
`endif

  // Grant decode depends only on the requests, the state and the arbitration
  // history. It never depends on the registered write port. On a tie, the
  // side that did not win last time gets the grant.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (w_arb_en) begin
      if (a_req && b_req) begin
        if (r_last_gnt == c_GNT_B) begin
          w_a_gnt = 1'b1;
        end else begin
          w_b_gnt = 1'b1;
        end
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // Next value of the write port. When no write is issued, the address and
  // data registers keep their previous values. A grant to address 0 updates
  // the arbitration history, but it does not produce a write.
  always_comb begin
    w_we_d       = 1'b0;
    w_waddr_d    = r_waddr;
    w_wdata_d    = r_wdata;
    w_last_gnt_d = r_last_gnt;
    if (w_a_gnt) begin
      w_last_gnt_d = c_GNT_A;
      if (a_addr != '0) begin
        w_we_d    = 1'b1;
        w_waddr_d = a_addr;
        w_wdata_d = a_data;
      end
    end else if (w_b_gnt) begin
      w_last_gnt_d = c_GNT_B;
      if (b_addr != '0) begin
        w_we_d    = 1'b1;
        w_waddr_d = b_addr;
        w_wdata_d = b_data;
      end
    end
`ifdef RF_CLEAR_EN
    // No grants are issued during CLEAR, so this path never collides with
    // the grant path above.
    if (r_state == ST_CLEAR) begin
      w_we_d    = 1'b1;
      w_waddr_d = r_clr_ptr;
      w_wdata_d = '0;
    end
`endif
  end

  // Reset takes priority over any grant in the same cycle, so a write
  // granted in the reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_gnt <= c_GNT_B;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_last_gnt <= w_last_gnt_d;
      r_we       <= w_we_d;
      r_waddr    <= w_waddr_d;
      r_wdata    <= w_wdata_d;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule
`default_nettype wire
